// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel gradient datapath.
package sobel_pkg;

    // Default grayscale pixel width.
    localparam int DEF_COLORDEPTH = 8;
    // Latency of the gradient stage; sideband signals are delayed by the same amount.
    localparam int PIPE_LAT       = 3;

    localparam int GRAD_W = DEF_COLORDEPTH + 3;
    localparam int MAG_W_DEF = DEF_COLORDEPTH + 4;

    // Signed Gx/Gy, sized to hold +/-4*(2^COLORDEPTH-1).
    typedef logic signed [GRAD_W-1:0] grad_t;
    // Unsigned |Gx|+|Gy|, sized to hold 8*(2^COLORDEPTH-1).
    typedef logic [MAG_W_DEF-1:0]     mag_t;

endpackage

// File: rtl/sobel_delay_line.sv
// Fixed-depth shift register used to keep sideband signals aligned with the datapath.
module sobel_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    // Shift every cycle; stage 0 takes the input, the last stage drives the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sobel_kernel.sv
// 3x3 Sobel gradient stage: window build, Gx/Gy, saturated |Gx|+|Gy|, sideband delay.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int COLORDEPTH = DEF_COLORDEPTH,
    parameter int MAG_W      = COLORDEPTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_line_n2_i,
    input  logic [COLORDEPTH-1:0] px_line_n1_i,
    input  logic [COLORDEPTH-1:0] px_line_n0_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] edge_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    localparam int GW = COLORDEPTH + 3;
    localparam logic [COLORDEPTH-1:0] PIX_MAX = '1;

    // Window indexed [col][row]: col 2 is newest, row 0 is the top line (n2).
    logic [2:0][2:0][COLORDEPTH-1:0] win_q, win_d;
    logic [2:0][COLORDEPTH-1:0]      new_col;
    logic [1:0]                      col_cnt_q, col_cnt_d;
    logic [1:0]                      row_cnt_q, row_cnt_d;
    logic                            dv_prev_q, vs_prev_q;
    logic                            dv_fall, vs_rise, valid_win;

    // Stage qualifiers: vld_q carries window validity, en_q carries dv so that
    // edge_o only updates for real pixels and otherwise holds.
    logic [1:0]                      vld_q, en_q;
    logic signed [GW-1:0]            gx_q, gx_d, gy_q, gy_d;
    logic [GW-1:0]                   abs_x, abs_y;
    logic [MAG_W-1:0]                mag;
    logic [COLORDEPTH-1:0]           sat_mag, edge_q;
    logic [2:0]                      sb_out;

    function automatic logic signed [GW-1:0] sx(input logic [COLORDEPTH-1:0] p);
        return $signed({{(GW-COLORDEPTH){1'b0}}, p});
    endfunction

    assign new_col = {px_line_n0_i, px_line_n1_i, px_line_n2_i};

    // Window shift and border counters; a frame restart clears row_cnt even if a line ends the same cycle.
    always_comb begin
        dv_fall   = dv_prev_q & ~dv_i;
        vs_rise   = vs_i & ~vs_prev_q;
        valid_win = (col_cnt_q == 2'd2) && (row_cnt_q == 2'd2);
        win_d     = win_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (dv_i) begin
            win_d = {new_col, win_q[2], win_q[1]};
            if (col_cnt_q != 2'd2) col_cnt_d = col_cnt_q + 2'd1;
        end
        if (dv_fall) begin
            col_cnt_d = 2'd0;
            if (row_cnt_q != 2'd2) row_cnt_d = row_cnt_q + 2'd1;
        end
        if (vs_rise) row_cnt_d = 2'd0;
    end

    // Gx: right column minus left column; Gy: bottom row minus top row; centre taps weighted x2.
    always_comb begin
        gx_d = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
             - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
        gy_d = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
             - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
    end

    // Magnitude and saturation to the pixel range.
    always_comb begin
        abs_x   = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
        abs_y   = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
        mag     = MAG_W'(abs_x) + MAG_W'(abs_y);
        sat_mag = (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[COLORDEPTH-1:0];
    end

    // S1: window, counters and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q     <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            dv_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            dv_prev_q <= dv_i;
            vs_prev_q <= vs_i;
        end
    end

    // S1..S3 qualifiers, S2 gradients, S3 output register (held while no pixel arrives).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            en_q   <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
            edge_q <= '0;
        end else begin
            vld_q  <= {vld_q[0], dv_i & valid_win};
            en_q   <= {en_q[0], dv_i};
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            if (en_q[1]) edge_q <= vld_q[1] ? sat_mag : '0;
        end
    end

    sobel_delay_line #(
        .WIDTH(3),
        .DEPTH(PIPE_LAT)
    ) u_sideband (
        .clk   (clk),
        .rst   (rst),
        .din_i ({dv_i, hs_i, vs_i}),
        .dout_o(sb_out)
    );

    assign {dv_o, hs_o, vs_o} = sb_out;
    assign edge_o             = edge_q;

endmodule

// File: tb/tb_sobel_kernel.sv
// Scoreboard bench for sobel_kernel: driver pushes expected records, monitor pops per cycle.
module tb_sobel_kernel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] px_line_n2_i = '0, px_line_n1_i = '0, px_line_n0_i = '0;
    logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [7:0] edge_o;
    logic       dv_o, hs_o, vs_o;

    sobel_kernel #(.COLORDEPTH(8), .MAG_W(12)) dut (
        .clk(clk), .rst(rst),
        .px_line_n2_i(px_line_n2_i), .px_line_n1_i(px_line_n1_i), .px_line_n0_i(px_line_n0_i),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .edge_o(edge_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dv;
        logic       hs;
        logic       vs;
        logic [7:0] edge_v;
    } rec_t;

    rec_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: pixels seen so far in the current line, lines completed in the frame.
    logic [7:0] lt[$], lm[$], lb[$];
    int         lines_done;
    bit         prev_dv, prev_vs;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_grad(input int at, am, ab, bt, bb, ct, cm, cb);
        int gx, gy, mag;
        gx  = (ct + 2*cm + cb) - (at + 2*am + ab);
        gy  = (ab + 2*bb + cb) - (at + 2*bt + ct);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 8'd255 : 8'(mag);
    endfunction

    // Present one cycle of inputs and record what should emerge 3 cycles later.
    task automatic apply(input logic [7:0] t, m, b, input logic dv, hs, vs);
        rec_t r;
        px_line_n2_i = t; px_line_n1_i = m; px_line_n0_i = b;
        dv_i = dv; hs_i = hs; vs_i = vs;
        r.dv = dv; r.hs = hs; r.vs = vs; r.edge_v = 8'd0;
        if (dv) begin
            if (lt.size() == 2 && lines_done >= 2)
                r.edge_v = ref_grad(lt[0], lm[0], lb[0], lt[1], lb[1], t, m, b);
            lt.push_back(t); lm.push_back(m); lb.push_back(b);
            if (lt.size() > 2) begin
                void'(lt.pop_front()); void'(lm.pop_front()); void'(lb.pop_front());
            end
        end
        if (prev_dv && !dv) begin
            lt.delete(); lm.delete(); lb.delete();
            if (lines_done < 2) lines_done++;
        end
        if (vs && !prev_vs) lines_done = 0;
        prev_dv = dv;
        prev_vs = vs;
        sb.push_back(r);
    endtask

    task automatic drive(input logic [7:0] t, m, b, input logic dv, hs, vs);
        @(negedge clk);
        apply(t, m, b, dv, hs, vs);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at a negedge: drop reset, pipeline holds zeros for the first two output cycles.
    task automatic release_reset();
        rec_t z;
        z = '0;
        rst = 1'b0;
        sb.delete();
        sb.push_back(z);
        sb.push_back(z);
        lt.delete(); lm.delete(); lb.delete();
        lines_done = 0;
        prev_dv = 1'b0;
        prev_vs = 1'b0;
        apply(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_start();
        idle(1);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic pix(input int mode, input int ln, input int col, output logic [7:0] t, m, b);
        case (mode)
            0: begin t = 8'd100; m = 8'd100; b = 8'd100; end
            1: begin t = (col < 5) ? 8'd0 : 8'd255; m = t; b = t; end
            2: begin t = 8'd0; m = 8'd0; b = 8'd10; end
            3: begin t = 8'((col+ln)*9); m = 8'((col+ln+1)*9); b = 8'((col+ln+2)*9); end
            5: begin t = 8'd0; m = 8'd0; b = 8'd255; end
            default: begin t = 8'($urandom); m = 8'($urandom); b = 8'($urandom); end
        endcase
    endtask

    task automatic send_line(input int mode, input int ln, input int gapmax, input int vs_at);
        logic [7:0] t, m, b;
        for (int c = 0; c < 10; c++) begin
            if (gapmax > 0 && c > 0) idle($urandom_range(gapmax, 0));
            pix(mode, ln, c, t, m, b);
            drive(t, m, b, 1'b1, 1'b0, (c == vs_at));
        end
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        idle(2);
    endtask

    task automatic send_frame(input int mode, input int nlines, input int gapmax);
        frame_start();
        for (int l = 0; l < nlines; l++) send_line(mode, l, gapmax, -1);
    endtask

    // Monitor: one record per clock once out of reset.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() >= 3) begin
                r = sb.pop_front();
                check("sideband", {29'd0, dv_o, hs_o, vs_o}, {29'd0, r.dv, r.hs, r.vs});
                if (r.dv) check("edge", {24'd0, edge_o}, {24'd0, r.edge_v});
            end
        end
    end

    initial begin
        logic [7:0] t, m, b;
        repeat (3) @(negedge clk);
        release_reset();

        send_frame(0, 3, 0);   // flat field
        send_frame(1, 3, 0);   // vertical step
        send_frame(2, 3, 0);   // horizontal step
        send_frame(3, 4, 0);   // diagonal ramp, contiguous
        send_frame(3, 4, 5);   // diagonal ramp with dv gaps
        send_frame(4, 4, 2);   // random

        // Frame restart mid-line with high-contrast input.
        send_frame(5, 3, 0);
        send_line(5, 3, 0, 4);
        for (int l = 0; l < 3; l++) send_line(5, l, 0, -1);

        // Asynchronous reset in the middle of a line.
        send_frame(5, 2, 0);
        for (int c = 0; c < 6; c++) begin
            pix(5, 2, c, t, m, b);
            drive(t, m, b, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_edge", {24'd0, edge_o}, 32'd0);
        check("rst_dv", {31'd0, dv_o}, 32'd0);
        check("rst_hs", {31'd0, hs_o}, 32'd0);
        check("rst_vs", {31'd0, vs_o}, 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        send_line(5, 0, 0, -1);   // no frame start yet: border-zeroed
        send_frame(4, 4, 1);

        idle(6);
        @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
